// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle RV32I control unit
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXECR     = 4'd6,
        S_EXECI     = 4'd7,
        S_ALUWB     = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR_ADR  = 4'd11,
        S_JALR_PC   = 4'd12,
        S_UPPER     = 4'd13,
        S_TRAP      = 4'd14
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // How the current state wants the ALU driven: fixed add, fixed subtract, or decoded from funct fields
    typedef enum logic [1:0] {
        AC_ADD   = 2'd0,
        AC_SUB   = 2'd1,
        AC_FUNCT = 2'd2
    } alu_class_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Immediate format depends only on the opcode; unknown opcodes fall back to I
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL:           return IMM_J;
            default:          return IMM_I;
        endcase
    endfunction

    // Dispatch out of DECODE; anything not recognised traps
    function automatic state_e decode_next(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_R:              return S_EXECR;
            OP_I:              return S_EXECI;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR_ADR;
            OP_LUI, OP_AUIPC:  return S_UPPER;
            default:           return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: instruction/flag inputs and datapath control outputs of the control unit
interface multicycle_control_unit_if #(
    parameter int ALUCTRL_W = 4
);
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic [3:0]           flags;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 adr_src;
    logic                 mem_read;
    logic                 mem_write;
    logic                 ir_write;
    logic                 reg_write;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           result_src;
    logic [2:0]           imm_src;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 illegal_instr;
    logic [3:0]           state_o;

    modport master (
        input  opcode, funct3, funct7b5, flags, mem_ready,
        output pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
        output alu_src_a, alu_src_b, result_src, imm_src, alu_control,
        output illegal_instr, state_o
    );

    modport slave (
        output opcode, funct3, funct7b5, flags, mem_ready,
        input  pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
        input  alu_src_a, alu_src_b, result_src, imm_src, alu_control,
        input  illegal_instr, state_o
    );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: maps state class and funct fields to the ALU operation code
module alu_decoder
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  alu_class_e           alu_class,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic [6:0]           opcode,
    output logic [ALUCTRL_W-1:0] alu_control
);
    alu_op_e op;

    // SUB only for R-type with funct7b5; in I-type that bit belongs to the immediate
    always_comb begin
        op = ALU_ADD;
        if (alu_class == AC_SUB) begin
            op = ALU_SUB;
        end else if (alu_class == AC_FUNCT) begin
            case (funct3)
                3'b000:  op = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  op = ALU_SLL;
                3'b010:  op = ALU_SLT;
                3'b011:  op = ALU_SLTU;
                3'b100:  op = ALU_XOR;
                3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  op = ALU_OR;
                default: op = ALU_AND;
            endcase
        end
    end

    assign alu_control = ALUCTRL_W'(op);
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multicycle control FSM driving a shared-memory datapath
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W     = 4,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input logic clk,
    input logic reset,
    multicycle_control_unit_if.master bus
);
    state_e     state_q, state_d;
    alu_class_e alu_class;
    logic       ready, taken, branch_ok;
    logic       pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw;

    assign ready     = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
    assign branch_ok = bus.funct3[2:1] != 2'b01;

    // State register; reset returns to FETCH immediately, abandoning any instruction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Branch condition from ALU flags of rs1 - rs2 computed this cycle
    always_comb begin
        taken = 1'b0;
        case (bus.funct3)
            3'b000:  taken = bus.flags[FLAG_Z];
            3'b001:  taken = !bus.flags[FLAG_Z];
            3'b100:  taken = bus.flags[FLAG_N] ^ bus.flags[FLAG_V];
            3'b101:  taken = !(bus.flags[FLAG_N] ^ bus.flags[FLAG_V]);
            3'b110:  taken = !bus.flags[FLAG_C];
            3'b111:  taken = bus.flags[FLAG_C];
            default: taken = 1'b0;
        endcase
    end

    // Next state and Moore outputs per state; write strobes are gated by reset below
    always_comb begin
        state_d           = state_q;
        pc_write_raw      = 1'b0;
        ir_write_raw      = 1'b0;
        reg_write_raw     = 1'b0;
        mem_write_raw     = 1'b0;
        bus.adr_src       = 1'b0;
        bus.mem_read      = 1'b0;
        bus.alu_src_a     = SRCA_PC;
        bus.alu_src_b     = SRCB_RS2;
        bus.result_src    = RES_ALUOUT;
        bus.illegal_instr = 1'b0;
        alu_class         = AC_ADD;
        case (state_q)
            S_FETCH: begin
                bus.mem_read   = 1'b1;
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALU;
                pc_write_raw   = ready;
                ir_write_raw   = ready;
                state_d        = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                state_d       = decode_next(bus.opcode);
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.adr_src  = 1'b1;
                bus.mem_read = 1'b1;
                state_d      = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                bus.result_src = RES_MEM;
                reg_write_raw  = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.adr_src   = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                bus.alu_src_a = SRCA_RS1;
                alu_class     = AC_FUNCT;
                state_d       = S_ALUWB;
            end
            S_EXECI: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                alu_class     = AC_FUNCT;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a = SRCA_RS1;
                alu_class     = AC_SUB;
                pc_write_raw  = branch_ok && taken;
                state_d       = branch_ok ? S_FETCH : S_TRAP;
            end
            S_JAL, S_JALR_PC: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                pc_write_raw  = 1'b1;
                state_d       = S_ALUWB;
            end
            S_JALR_ADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = S_JALR_PC;
            end
            S_UPPER: begin
                bus.alu_src_a = (bus.opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                state_d       = S_ALUWB;
            end
            S_TRAP: begin
                bus.illegal_instr = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign bus.pc_write  = reset & pc_write_raw;
    assign bus.ir_write  = reset & ir_write_raw;
    assign bus.reg_write = reset & reg_write_raw;
    assign bus.mem_write = reset & mem_write_raw;
    assign bus.imm_src   = imm_sel(bus.opcode);
    assign bus.state_o   = state_q;

    alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decoder (
        .alu_class   (alu_class),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .opcode      (bus.opcode),
        .alu_control (bus.alu_control)
    );
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: per-cycle scoreboard check of state sequence and control outputs
module tb_multicycle_control_unit;
    import ctrl_pkg::*;

    localparam int X = -1;
    localparam logic [5:0] K_NONE  = 6'b000000;
    localparam logic [5:0] K_FET   = 6'b110100;
    localparam logic [5:0] K_FWAIT = 6'b000100;
    localparam logic [5:0] K_RW    = 6'b001000;
    localparam logic [5:0] K_MW    = 6'b000010;
    localparam logic [5:0] K_PC    = 6'b100000;
    localparam logic [5:0] K_IL    = 6'b000001;

    typedef struct {
        int         st;
        logic [5:0] stb;
        int         alu;
        int         a;
        int         b;
        int         rs;
        int         adr;
    } exp_t;

    typedef struct { int op; int f3; int f7; int alu; } alu_t;
    typedef struct { int f3; int fl; int tk; } br_t;

    logic  clk   = 1'b0;
    logic  reset = 1'b0;
    exp_t  sb[$];
    int    n_chk   = 0;
    int    n_fail  = 0;
    int    cur_imm = X;
    int    cyc     = 0;
    string cur_test = "reset";

    multicycle_control_unit_if #(.ALUCTRL_W(4)) bus ();
    multicycle_control_unit_if #(.ALUCTRL_W(4)) bus0 ();

    multicycle_control_unit #(.ALUCTRL_W(4), .MEM_HANDSHAKE(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    multicycle_control_unit #(.ALUCTRL_W(4), .MEM_HANDSHAKE(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    assign bus0.opcode    = bus.opcode;
    assign bus0.funct3    = bus.funct3;
    assign bus0.funct7b5  = bus.funct7b5;
    assign bus0.flags     = bus.flags;
    assign bus0.mem_ready = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare();
        exp_t  e;
        string t;
        e = sb.pop_front();
        t = $sformatf("%s[%0d]", cur_test, cyc);
        check({t, ".state"}, 32'(bus.state_o), e.st);
        check({t, ".strobes"}, 32'({bus.pc_write, bus.ir_write, bus.reg_write,
                                    bus.mem_read, bus.mem_write, bus.illegal_instr}), 32'(e.stb));
        if (cur_imm != X) check({t, ".imm_src"}, 32'(bus.imm_src), cur_imm);
        if (e.alu != X)   check({t, ".alu_control"}, 32'(bus.alu_control), e.alu);
        if (e.a != X)     check({t, ".alu_src_a"}, 32'(bus.alu_src_a), e.a);
        if (e.b != X)     check({t, ".alu_src_b"}, 32'(bus.alu_src_b), e.b);
        if (e.rs != X)    check({t, ".result_src"}, 32'(bus.result_src), e.rs);
        if (e.adr != X)   check({t, ".adr_src"}, 32'(bus.adr_src), e.adr);
        cyc++;
    endtask

    task automatic step(input logic rst_v, input logic rdy, input logic [3:0] fl,
                        input int st, input logic [5:0] stb,
                        input int alu = X, input int a = X, input int b = X,
                        input int rs = X, input int adr = X);
        exp_t e;
        @(negedge clk);
        reset         = rst_v;
        bus.mem_ready = rdy;
        bus.flags     = fl;
        e.st = st; e.stb = stb; e.alu = alu; e.a = a; e.b = b; e.rs = rs; e.adr = adr;
        sb.push_back(e);
        #1 compare();
    endtask

    task automatic instr(input string name, input int op, input int f3, input int f7, input int imm);
        cur_test     = name;
        cyc          = 0;
        bus.opcode   = 7'(op);
        bus.funct3   = 3'(f3);
        bus.funct7b5 = 1'(f7);
        cur_imm      = imm;
    endtask

    task automatic fetch_decode();
        step(1'b1, 1'b1, 4'h0, S_FETCH, K_FET, ALU_ADD, 0, 2, 2, 0);
        step(1'b1, 1'b1, 4'h0, S_DECODE, K_NONE, ALU_ADD, 1, 1);
    endtask

    alu_t alu_tab[12] = '{
        '{OP_R, 0, 0, 0}, '{OP_R, 0, 1, 1}, '{OP_R, 1, 0, 5}, '{OP_R, 2, 0, 8},
        '{OP_R, 3, 0, 9}, '{OP_R, 4, 0, 4}, '{OP_R, 5, 1, 7}, '{OP_R, 6, 0, 3},
        '{OP_R, 7, 0, 2}, '{OP_I, 0, 1, 0}, '{OP_I, 5, 1, 7}, '{OP_I, 5, 0, 6}
    };

    br_t br_tab[11] = '{
        '{4, 4'b0010, 1}, '{4, 4'b1010, 0}, '{7, 4'b0100, 1}, '{7, 4'b0000, 0},
        '{0, 4'b0001, 1}, '{0, 4'b0000, 0}, '{1, 4'b0000, 1}, '{1, 4'b0001, 0},
        '{5, 4'b1010, 1}, '{6, 4'b0100, 0}, '{6, 4'b0000, 1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        bus.opcode = OP_R; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
        bus.flags = 4'h0; bus.mem_ready = 1'b1;
        step(1'b0, 1'b1, 4'h0, S_FETCH, K_FWAIT, ALU_ADD, 0, 2, 2, 0);
        step(1'b0, 1'b1, 4'h0, S_FETCH, K_FWAIT, ALU_ADD, 0, 2, 2, 0);

        foreach (alu_tab[i]) begin
            instr($sformatf("alu%0d", i), alu_tab[i].op, alu_tab[i].f3, alu_tab[i].f7,
                  alu_tab[i].op == int'(OP_R) ? X : int'(IMM_I));
            fetch_decode();
            if (alu_tab[i].op == int'(OP_R))
                step(1'b1, 1'b1, 4'h0, S_EXECR, K_NONE, alu_tab[i].alu, 2, 0);
            else
                step(1'b1, 1'b1, 4'h0, S_EXECI, K_NONE, alu_tab[i].alu, 2, 1);
            step(1'b1, 1'b1, 4'h0, S_ALUWB, K_RW, X, X, X, 0);
        end

        instr("lw", OP_LOAD, 2, 0, IMM_I);
        fetch_decode();
        step(1'b1, 1'b1, 4'h0, S_MEMADR, K_NONE, ALU_ADD, 2, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, S_MEMREAD, K_FWAIT, X, X, X, X, 1);
        step(1'b1, 1'b1, 4'h0, S_MEMREAD, K_FWAIT, X, X, X, X, 1);
        step(1'b1, 1'b1, 4'h0, S_MEMWB, K_RW, X, X, X, 1);

        foreach (br_tab[i]) begin
            instr($sformatf("br%0d", i), OP_BRANCH, br_tab[i].f3, 0, IMM_B);
            fetch_decode();
            step(1'b1, 1'b1, 4'(br_tab[i].fl), S_BRANCH, br_tab[i].tk != 0 ? K_PC : K_NONE,
                 ALU_SUB, 2, 0, 0);
        end

        instr("jal", OP_JAL, 0, 0, IMM_J);
        fetch_decode();
        step(1'b1, 1'b1, 4'h0, S_JAL, K_PC, ALU_ADD, 1, 2, 0);
        step(1'b1, 1'b1, 4'h0, S_ALUWB, K_RW, X, X, X, 0);

        instr("jalr", OP_JALR, 0, 0, IMM_I);
        fetch_decode();
        step(1'b1, 1'b1, 4'h0, S_JALR_ADR, K_NONE, ALU_ADD, 2, 1);
        step(1'b1, 1'b1, 4'h0, S_JALR_PC, K_PC, ALU_ADD, 1, 2, 0);
        step(1'b1, 1'b1, 4'h0, S_ALUWB, K_RW, X, X, X, 0);

        instr("lui", OP_LUI, 0, 0, IMM_U);
        fetch_decode();
        step(1'b1, 1'b1, 4'h0, S_UPPER, K_NONE, ALU_ADD, 3, 1);
        step(1'b1, 1'b1, 4'h0, S_ALUWB, K_RW, X, X, X, 0);

        instr("auipc", OP_AUIPC, 0, 0, IMM_U);
        fetch_decode();
        step(1'b1, 1'b1, 4'h0, S_UPPER, K_NONE, ALU_ADD, 1, 1);
        step(1'b1, 1'b1, 4'h0, S_ALUWB, K_RW, X, X, X, 0);

        instr("sw", OP_STORE, 2, 0, IMM_S);
        step(1'b1, 1'b0, 4'h0, S_FETCH, K_FWAIT, ALU_ADD, 0, 2, 2, 0);
        fetch_decode();
        step(1'b1, 1'b1, 4'h0, S_MEMADR, K_NONE, ALU_ADD, 2, 1);
        step(1'b1, 1'b0, 4'h0, S_MEMWRITE, K_MW, X, X, X, X, 1);
        step(1'b1, 1'b0, 4'h0, S_MEMWRITE, K_MW, X, X, X, X, 1);
        step(1'b0, 1'b0, 4'h0, S_FETCH, K_FWAIT, ALU_ADD, 0, 2, 2, 0);
        fetch_decode();
        step(1'b1, 1'b1, 4'h0, S_MEMADR, K_NONE, ALU_ADD, 2, 1);
        step(1'b1, 1'b1, 4'h0, S_MEMWRITE, K_MW, X, X, X, X, 1);
        step(1'b1, 1'b1, 4'h0, S_FETCH, K_FET, ALU_ADD, 0, 2, 2, 0);
        step(1'b1, 1'b1, 4'h0, S_DECODE, K_NONE, ALU_ADD, 1, 1);
        step(1'b1, 1'b1, 4'h0, S_MEMADR, K_NONE, ALU_ADD, 2, 1);
        step(1'b1, 1'b1, 4'h0, S_MEMWRITE, K_MW, X, X, X, X, 1);

        instr("bad_br", OP_BRANCH, 2, 0, IMM_B);
        fetch_decode();
        step(1'b1, 1'b1, 4'b0001, S_BRANCH, K_NONE);
        step(1'b1, 1'b1, 4'h0, S_TRAP, K_IL);
        step(1'b0, 1'b1, 4'h0, S_FETCH, K_FWAIT, ALU_ADD, 0, 2, 2, 0);

        instr("illegal", 7'h7F, 0, 0, X);
        fetch_decode();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'h0, S_TRAP, K_IL);
        step(1'b0, 1'b1, 4'h0, S_FETCH, K_FWAIT, ALU_ADD, 0, 2, 2, 0);

        instr("nohs", OP_R, 0, 0, X);
        step(1'b1, 1'b1, 4'h0, S_FETCH, K_FET, ALU_ADD, 0, 2, 2, 0);
        check("nohs.dut0_state0", 32'(bus0.state_o), S_FETCH);
        check("nohs.dut0_pc_write0", 32'(bus0.pc_write), 1);
        step(1'b1, 1'b1, 4'h0, S_DECODE, K_NONE, ALU_ADD, 1, 1);
        check("nohs.dut0_state1", 32'(bus0.state_o), S_DECODE);
        step(1'b1, 1'b1, 4'h0, S_EXECR, K_NONE, ALU_ADD, 2, 0);
        check("nohs.dut0_state2", 32'(bus0.state_o), S_EXECR);
        step(1'b1, 1'b1, 4'h0, S_ALUWB, K_RW, X, X, X, 0);
        check("nohs.dut0_state3", 32'(bus0.state_o), S_ALUWB);
        step(1'b1, 1'b1, 4'h0, S_FETCH, K_FET, ALU_ADD, 0, 2, 2, 0);
        check("nohs.dut0_state4", 32'(bus0.state_o), S_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
